// File: rtl/systolic_drain_if.sv
// Bus bundle between the systolic array bottom row, the drain block and the host-side consumer.
// The slave modport is the drain block's view; master is the array/host side.
interface systolic_drain_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
);
    logic                     in_valid;
    logic [N*W-1:0]           acc_col;
    logic                     full;
    logic                     overflow;
    logic                     out_valid;
    logic                     out_ready;
    logic [N*W-1:0]           out_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid,
        output acc_col,
        output out_ready,
        input  full,
        input  overflow,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_valid,
        input  acc_col,
        input  out_ready,
        output full,
        output overflow,
        output out_valid,
        output out_data,
        output count
    );
endinterface

// File: rtl/systolic_drain.sv
// Deskews time-skewed bottom-row AccOut columns into aligned rows and buffers them in a small
// FIFO with a valid/ready host port. The array cannot stall, so dropped rows set a sticky flag.
module systolic_drain #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             clr,
    systolic_drain_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = N * W;

    logic          flush;
    logic [RW-1:0] aligned;
    logic [N-2:0]  vpipe_q;
    logic [RW-1:0] row_q;
    logic          row_valid_q;
    logic [RW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          out_valid;
    logic          is_full;
    logic          pop;
    logic          push;
    logic          drop;

    assign flush = rst | clr;

    // Column j arrives j edges after its row starts, so it needs N-1-j stages to line up.
    for (genvar j = 0; j < N; j++) begin : g_col
        if (j == N - 1) begin : g_direct
            assign aligned[j*W +: W] = bus.acc_col[j*W +: W];
        end else begin : g_pipe
            localparam int unsigned Stages = N - 1 - j;
            logic [W-1:0] pipe_q [Stages];

            always_ff @(posedge clk) begin
                if (flush) begin
                    for (int s = 0; s < int'(Stages); s++) begin
                        pipe_q[s] <= '0;
                    end
                end else begin
                    pipe_q[0] <= bus.acc_col[j*W +: W];
                    for (int s = 1; s < int'(Stages); s++) begin
                        pipe_q[s] <= pipe_q[s-1];
                    end
                end
            end

            assign aligned[j*W +: W] = pipe_q[Stages-1];
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q[0] <= bus.in_valid;
            for (int s = 1; s < int'(N) - 1; s++) begin
                vpipe_q[s] <= vpipe_q[s-1];
            end
        end
    end

    // Aligned row is captured here, then pushed into the FIFO on the following edge.
    always_ff @(posedge clk) begin
        if (flush) begin
            row_q       <= '0;
            row_valid_q <= 1'b0;
        end else begin
            row_valid_q <= vpipe_q[N-2];
            if (vpipe_q[N-2]) begin
                row_q <= aligned;
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign is_full   = (count_q == CW'(DEPTH));

    always_comb begin
        pop     = out_valid & bus.out_ready;
        push    = row_valid_q & (~is_full | pop);
        drop    = row_valid_q & is_full & ~pop;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // When full with a same-edge pop, wr_ptr equals rd_ptr and the slot being vacated is reused.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= row_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_systolic_drain.sv
// Randomised bench for systolic_drain: drives skewed rows and compares every cycle against a
// row-level queue model of the deskew latency and FIFO rules.
module tb_systolic_drain;
    localparam int unsigned N     = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = N * W;

    typedef struct {
        int            start;
        logic [RW-1:0] data;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    always #5 clk = ~clk;

    systolic_drain_if #(.N(N), .W(W), .DEPTH(DEPTH)) bus ();

    systolic_drain #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    row_t          inflight[$];
    logic [RW-1:0] fifo_m[$];
    bit            ovf_m;
    int            cyc;
    int            n_checks;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [RW-1:0] got,
                            input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model on the edge, compare 1ns later.
    task automatic tick(input bit v, input logic [RW-1:0] row, input bit rdy,
                        input bit r, input bit c);
        logic [RW-1:0] col;
        logic [RW-1:0] done_data;
        bit            pop;
        bit            done;
        bit            was_full;
        if (v) inflight.push_back('{start: cyc, data: row});
        col = '0;
        for (int j = 0; j < int'(N); j++) begin
            logic [W-1:0] cv;
            cv = W'($urandom);
            foreach (inflight[i]) begin
                if (inflight[i].start == cyc - j) cv = inflight[i].data[j*W +: W];
            end
            col[j*W +: W] = cv;
        end
        bus.in_valid  = v;
        bus.acc_col   = col;
        bus.out_ready = rdy;
        rst           = r;
        clr           = c;
        pop           = (fifo_m.size() != 0) && rdy;
        @(posedge clk);
        if (r || c) begin
            inflight.delete();
            fifo_m.delete();
            ovf_m = 1'b0;
        end else begin
            done      = 1'b0;
            done_data = '0;
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i].start == cyc - int'(N)) begin
                    done      = 1'b1;
                    done_data = inflight[i].data;
                    inflight.delete(i);
                    break;
                end
            end
            was_full = (fifo_m.size() == int'(DEPTH));
            if (pop) void'(fifo_m.pop_front());
            if (done) begin
                if (was_full && !pop) ovf_m = 1'b1;
                else fifo_m.push_back(done_data);
            end
        end
        cyc++;
        #1;
        check_eq("out_valid", bus.out_valid, fifo_m.size() != 0);
        check_eq("count", bus.count, fifo_m.size());
        check_eq("full", bus.full, fifo_m.size() == int'(DEPTH));
        check_eq("overflow", bus.overflow, ovf_m);
        if (fifo_m.size() != 0) check_eq("out_data", bus.out_data, fifo_m[0]);
        if (r || c) check_eq("out_data_after_flush", bus.out_data, '0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    function automatic logic [RW-1:0] tagged_row(input int k);
        logic [RW-1:0] r;
        for (int j = 0; j < int'(N); j++) r[j*W +: W] = W'((k << 8) | j);
        return r;
    endfunction

    function automatic logic [RW-1:0] edge_row();
        logic [RW-1:0] r;
        for (int j = 0; j < int'(N); j++) begin
            case ($urandom_range(0, 2))
                0:       r[j*W +: W] = 16'h8000;
                1:       r[j*W +: W] = 16'hFFFF;
                default: r[j*W +: W] = W'($urandom);
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [RW-1:0] r;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        ovf_m    = 1'b0;

        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Single row, columns 0x0100+j
        for (int j = 0; j < int'(N); j++) r[j*W +: W] = W'(16'h0100 + j);
        tick(1'b1, r, 1'b1, 1'b0, 1'b0);
        idle(N + 3, 1'b1);

        // Six back-to-back rows
        for (int k = 0; k < 6; k++) tick(1'b1, tagged_row(k), 1'b1, 1'b0, 1'b0);
        idle(N + 3, 1'b1);

        // Overfill with consumer stalled, then drain
        for (int k = 0; k < 5; k++) tick(1'b1, tagged_row(k + 16), 1'b0, 1'b0, 1'b0);
        idle(N + 2, 1'b0);
        idle(DEPTH + 2, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Full FIFO with a pop on the same edge the next row lands
        for (int k = 0; k < int'(DEPTH); k++) tick(1'b1, tagged_row(k + 32), 1'b0, 1'b0, 1'b0);
        idle(N + 1, 1'b0);
        tick(1'b1, tagged_row(40), 1'b0, 1'b0, 1'b0);
        idle(N - 1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Reset while a row is in the deskew pipes
        tick(1'b1, tagged_row(50), 1'b1, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(N + 3, 1'b1);

        // Random rows with sign-edge values and random stalls
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 1) == 1, edge_row(), $urandom_range(0, 2) != 0,
                 1'b0, i == 200);
        end
        idle(N + DEPTH + 4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
